// File: rtl/rounding_vec.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : rounding_vec
// Description : Frame-based threshold classifier. Accepts NCH signed scores,
//               one per accepted cycle, compares each against a threshold
//               captured at the start of the frame and publishes the packed
//               decision vector, its population count and (optionally) the
//               index of the largest score with a one-cycle valid pulse.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Optional feature macro:
//   ROUNDING_VEC_ARGMAX_EN  - build the running-maximum tracker that drives
//                             argmax_idx. Undefined: argmax_idx is tied to 0.
// ----------------------------------------------------------------------------
// Parameters:
//   DWIDTH  score/threshold width, two's complement
//   FRAC    fractional bits of the Q format (informational only)
//   NCH     scores per frame (>= 1)
//   IDXW    element index / argmax width   (derived)
//   CNTW    ones-count width               (derived)
// Ports:
//   clk         in   1       rising-edge clock
//   reset       in   1       synchronous active-high reset
//   en          in   1       input score valid
//   in          in   DWIDTH  signed score
//   thresh      in   DWIDTH  signed threshold
//   in_ready    out  1       score can be accepted this cycle
//   out         out  NCH     packed decisions, bit k = score k
//   out_valid   out  1       one-cycle pulse when outputs update
//   ones_cnt    out  CNTW    number of set bits in out
//   argmax_idx  out  IDXW    index of the largest score of the frame
// ============================================================================
module rounding_vec #(
    parameter  int DWIDTH = 32,
    parameter  int FRAC   = 24,
    parameter  int NCH    = 16,
    localparam int IDXW   = (NCH > 1) ? $clog2(NCH) : 1,
    localparam int CNTW   = $clog2(NCH + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic [DWIDTH-1:0] in,
    input  logic [DWIDTH-1:0] thresh,
    output logic              in_ready,
    output logic [NCH-1:0]    out,
    output logic              out_valid,
    output logic [CNTW-1:0]   ones_cnt,
    output logic [IDXW-1:0]   argmax_idx
);

    localparam logic [IDXW-1:0] c_LAST_IDX = IDXW'(NCH - 1);
    localparam logic [IDXW-1:0] c_IDX_ONE  = IDXW'(1);

    // FRAC only names the fixed-point format; the compare is width-exact.
    generate
        if (FRAC < 0 || FRAC > DWIDTH) begin : g_frac_unusual
            // No hardware: an out-of-range FRAC only affects interpretation.
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_DONE    = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [IDXW-1:0]     idx_q, idx_d;
    logic [NCH-1:0]      shadow_q, shadow_d;
    logic [DWIDTH-1:0]   thr_q, thr_d;
    logic [NCH-1:0]      out_q, out_d;
    logic                out_valid_q, out_valid_d;
    logic [CNTW-1:0]     ones_q, ones_d;

    logic                w_xfer;
    logic [DWIDTH-1:0]   w_thr_sel;
    logic                w_bit;

    function automatic logic [CNTW-1:0] f_popcount(input logic [NCH-1:0] vec);
        logic [CNTW-1:0] cnt;
        cnt = '0;
        for (int k = 0; k < NCH; k++) begin
            cnt = cnt + CNTW'(vec[k]);
        end
        return cnt;
    endfunction

    assign in_ready = (state_q != S_DONE);
    assign w_xfer   = en && in_ready;

    // Element 0 arrives in the same cycle the threshold is captured, so it
    // must compare against the live input rather than the stale register.
    assign w_thr_sel = (state_q == S_IDLE) ? thresh : thr_q;
    assign w_bit     = ($signed(in) >= $signed(w_thr_sel));

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        shadow_d    = shadow_q;
        thr_d       = thr_q;
        out_d       = out_q;
        out_valid_d = 1'b0;
        ones_d      = ones_q;

        case (state_q)
            S_IDLE: begin
                if (w_xfer) begin
                    thr_d       = thresh;
                    // Fresh frame: old decisions must never leak through.
                    shadow_d    = '0;
                    shadow_d[0] = w_bit;
                    idx_d       = c_IDX_ONE;
                    state_d     = (NCH == 1) ? S_DONE : S_COLLECT;
                end
            end
            S_COLLECT: begin
                if (w_xfer) begin
                    shadow_d[idx_q] = w_bit;
                    idx_d           = idx_q + c_IDX_ONE;
                    if (idx_q == c_LAST_IDX) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                out_d       = shadow_q;
                ones_d      = f_popcount(shadow_q);
                out_valid_d = 1'b1;
                idx_d       = '0;
                state_d     = S_IDLE;
            end
            default: begin
                idx_d   = '0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            idx_q       <= '0;
            shadow_q    <= '0;
            thr_q       <= '0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
            ones_q      <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            shadow_q    <= shadow_d;
            thr_q       <= thr_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            ones_q      <= ones_d;
        end
    end

    assign out       = out_q;
    assign out_valid = out_valid_q;
    assign ones_cnt  = ones_q;

`ifdef ROUNDING_VEC_ARGMAX_EN
    logic [DWIDTH-1:0] max_q, max_d;
    logic [IDXW-1:0]   max_idx_q, max_idx_d;
    logic [IDXW-1:0]   argmax_q, argmax_d;

    // Element 0 always seeds the tracker; later elements win only when
    // strictly greater, which keeps the lowest index on ties.
    always_comb begin
        max_d     = max_q;
        max_idx_d = max_idx_q;
        argmax_d  = argmax_q;
        if (state_q == S_IDLE && w_xfer) begin
            max_d     = in;
            max_idx_d = '0;
        end else if (state_q == S_COLLECT && w_xfer &&
                     ($signed(in) > $signed(max_q))) begin
            max_d     = in;
            max_idx_d = idx_q;
        end
        if (state_q == S_DONE) begin
            argmax_d = max_idx_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            max_q     <= '0;
            max_idx_q <= '0;
            argmax_q  <= '0;
        end else begin
            max_q     <= max_d;
            max_idx_q <= max_idx_d;
            argmax_q  <= argmax_d;
        end
    end

    assign argmax_idx = argmax_q;
`else
    assign argmax_idx = '0;
`endif

endmodule
`default_nettype wire
